layer0_input_packer: RTL and testbench
======================================

LAYER0_INPUT_PACKER -- requirements
Module: layer0_input_packer

Interface
REQ-001 SHALL have parameter FEAT_WIDTH, default 2, giving the bit width of one quantized input feature.
REQ-002 SHALL have parameter FEAT_COUNT, default 16, giving the number of features per classification vector (range 2..256).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, reset that is asynchronous and active-low.
REQ-005 SHALL have port s_valid, input, 1 bit, upstream feature valid.
REQ-006 SHALL have port s_ready, output, 1 bit, packer can accept a feature.
REQ-007 SHALL have port s_data, input, FEAT_WIDTH bits, one quantized feature.
REQ-008 SHALL have port s_last, input, 1 bit, marks the final feature of a vector.
REQ-009 SHALL have port m_valid, output, 1 bit, packed vector valid toward the layer0 neuron array.
REQ-010 SHALL have port m_ready, input, 1 bit, layer0 pipeline accepts the vector.
REQ-011 SHALL have port m_data, output, FEAT_COUNT*FEAT_WIDTH bits, packed vector driving the layer0 neuron M0 inputs.
REQ-012 SHALL have port frame_err, output, 1 bit, one-cycle pulse on a framing error.

Function
REQ-013 SHALL treat a feature as accepted when s_valid and s_ready are high on a rising clk edge; data is transferred only on that condition.
REQ-014 SHALL write the feature with index k (0-based within a vector) to assembly bits [k*FEAT_WIDTH +: FEAT_WIDTH].
REQ-015 SHALL hold a feature index counter of width clog2(FEAT_COUNT); it increments on each accepted feature and returns to 0 after index FEAT_COUNT-1, with no other wrap.
REQ-016 SHALL implement two states: FILL (s_ready=1) and HOLD (s_ready=0, assembly complete and waiting for the output register).
REQ-017 SHALL, in FILL, on acceptance at index FEAT_COUNT-1 with s_last=1, copy the completed assembly (including this feature) to the output register if that register is empty or drains (m_valid and m_ready) in the same cycle; otherwise SHALL enter HOLD.
REQ-018 SHALL, in HOLD, transfer the assembly to the output register on the cycle the output drains, then return to FILL; s_ready SHALL be 1 again on the following cycle.
REQ-019 SHALL assert m_valid the cycle after the transfer into the output register, and SHALL hold m_valid and m_data stable until m_ready is sampled high.
REQ-020 SHALL sustain one feature per cycle with no bubbles when m_ready stays high; vector latency is 1 cycle from acceptance of the last feature to m_valid.
REQ-021 SHALL treat s_last=1 at an index below FEAT_COUNT-1 as an error: pulse frame_err for one cycle, discard the partial vector, and reset the index to 0.
REQ-022 SHALL treat s_last=0 at index FEAT_COUNT-1 as an error: pulse frame_err, discard the vector, and reset the index to 0; m_valid SHALL NOT assert for that vector.
REQ-023 SHALL leave the output register and m_valid unaffected by framing errors.
REQ-024 SHALL ignore s_data and s_last when s_valid=0.

Reset
REQ-025 SHALL, while rst_n=0, immediately force s_ready=0, m_valid=0, frame_err=0, m_data=0, index=0, state=FILL, and assembly=0.
REQ-026 SHALL drive s_ready=1 from the first rising clk edge after rst_n deasserts.
REQ-027 SHALL, on reset mid-vector or mid-HOLD, discard all partial and pending data; no vector present before reset SHALL appear on m_data afterward.

Verification (FEAT_WIDTH=2, FEAT_COUNT=16)
REQ-028 SHALL cover: 16 features with values k mod 4, s_last on k=15, m_ready=1 -> m_valid for exactly one cycle, one cycle after the last feature, m_data=32'hE4E4E4E4.
REQ-029 SHALL cover: three back-to-back vectors with continuous s_valid and m_ready=1 -> s_ready constantly 1, three m_valid pulses 16 cycles apart.
REQ-030 SHALL cover: m_ready=0 while two full vectors are sent -> first vector held stable on m_data, s_ready=0 after the second completes; raising m_ready -> first then second vector delivered in order, s_ready=1 again.
REQ-031 SHALL cover: s_last on index 5 -> frame_err pulses once, no m_valid; next 16-feature vector packs from index 0 correctly.
REQ-032 SHALL cover: index 15 accepted with s_last=0 -> frame_err pulses once, no m_valid, index returns to 0.
REQ-033 SHALL cover: rst_n asserted after 8 features and while a vector is pending on m_data -> m_valid=0 and s_ready=0 immediately; after release a fresh vector outputs only the new data.

Source files
------------

// File: rtl/layer0_input_packer_if.sv
// Feature-stream in / packed-vector out bundle for the layer0 input packer.
//   s_valid/s_ready/s_data/s_last : one quantized feature per handshake
//   m_valid/m_ready/m_data        : one packed vector toward the layer0 neurons
//   frame_err                     : one-cycle framing error pulse
// master : the environment (feature source + vector sink)
// slave  : the packer itself
interface layer0_input_packer_if #(
  parameter int FEAT_WIDTH = 2,
  parameter int FEAT_COUNT = 16
);
  logic                             s_valid;
  logic                             s_ready;
  logic [FEAT_WIDTH-1:0]            s_data;
  logic                             s_last;
  logic                             m_valid;
  logic                             m_ready;
  logic [FEAT_COUNT*FEAT_WIDTH-1:0] m_data;
  logic                             frame_err;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, frame_err
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, frame_err
  );
endinterface

// File: rtl/layer0_input_packer.sv
// Layer0 input packer: collects FEAT_COUNT quantized features from a
// valid/ready stream into one wide vector and hands it to the layer0 neuron
// array through a single output register.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : layer0_input_packer_if.slave (feature stream in, vector out,
//           frame_err pulse)
// A vector is framed by s_last on exactly index FEAT_COUNT-1; any other
// placement drops the partial vector and pulses frame_err.
module layer0_input_packer #(
  parameter int FEAT_WIDTH = 2,
  parameter int FEAT_COUNT = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  layer0_input_packer_if.slave  bus
);
  localparam int IW = $clog2(FEAT_COUNT);
  localparam logic [IW-1:0] LAST_IDX = IW'(FEAT_COUNT - 1);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]                             state;
  logic                                   run;     // low until first edge after reset
  logic [IW-1:0]                          idx;
  logic [FEAT_COUNT-1:0][FEAT_WIDTH-1:0]  asm_q;
  logic [FEAT_COUNT-1:0][FEAT_WIDTH-1:0]  asm_done;
  logic [FEAT_COUNT*FEAT_WIDTH-1:0]       m_data_q;
  logic                                   m_valid_q;
  logic                                   ferr_q;

  logic acc, last_idx, out_free;

  assign bus.s_ready   = run && (state == FILL);
  assign bus.m_valid   = m_valid_q;
  assign bus.m_data    = m_data_q;
  assign bus.frame_err = ferr_q;

  assign acc      = bus.s_valid && bus.s_ready;
  assign last_idx = (idx == LAST_IDX);
  assign out_free = !m_valid_q || bus.m_ready;

  // Completed vector including the feature being accepted this cycle, so a
  // finishing vector can go straight to the output register with no bubble.
  always_comb begin
    asm_done                 = asm_q;
    asm_done[FEAT_COUNT-1]   = bus.s_data;
  end

  // Per-slot assembly registers; frozen in HOLD because acc is low there.
  for (genvar k = 0; k < FEAT_COUNT; k++) begin : g_slot
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        asm_q[k] <= '0;
      else if (acc && idx == IW'(k))
        asm_q[k] <= bus.s_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      run       <= 1'b0;
      idx       <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      run    <= 1'b1;
      ferr_q <= 1'b0;

      // Drain first; a load below in the same cycle overrides it.
      if (m_valid_q && bus.m_ready)
        m_valid_q <= 1'b0;

      if (state == HOLD) begin
        // m_valid is necessarily high here, so m_ready alone means drain.
        if (bus.m_ready) begin
          m_data_q  <= asm_q;
          m_valid_q <= 1'b1;
          state     <= FILL;
        end
      end else if (acc) begin
        if (bus.s_last && last_idx) begin
          idx <= '0;
          if (out_free) begin
            m_data_q  <= asm_done;
            m_valid_q <= 1'b1;
          end else begin
            state <= HOLD;
          end
        end else if (bus.s_last || last_idx) begin
          // Early or missing s_last: drop the vector; the slots are simply
          // overwritten by the next one.
          ferr_q <= 1'b1;
          idx    <= '0;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_layer0_input_packer.sv
module tb_layer0_input_packer;
  localparam int FW = 2;
  localparam int FC = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  layer0_input_packer_if #(.FEAT_WIDTH(FW), .FEAT_COUNT(FC)) bus ();

  layer0_input_packer #(.FEAT_WIDTH(FW), .FEAT_COUNT(FC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        sv;
    logic [1:0]  sd;
    logic        sl;
    logic        mr;
    logic        e_mv;
    logic        e_sr;
    logic        e_fe;
    logic        chk_d;
    logic [31:0] e_d;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add(input logic sv, input logic [1:0] sd, input logic sl,
                     input logic mr, input logic mv, input logic sr,
                     input logic fe, input logic cd, input logic [31:0] d);
    vec_t r;
    r.sv = sv; r.sd = sd; r.sl = sl; r.mr = mr;
    r.e_mv = mv; r.e_sr = sr; r.e_fe = fe; r.chk_d = cd; r.e_d = d;
    tbl.push_back(r);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic sv, input logic [1:0] sd, input logic sl, input logic mr);
    bus.s_valid = sv;
    bus.s_data  = sd;
    bus.s_last  = sl;
    bus.m_ready = mr;
  endtask

  function automatic logic [1:0] f(input int k, input int off);
    f = 2'((k + off) % 4);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] dv [3];
    dv[0] = 32'hE4E4E4E4;
    dv[1] = 32'h39393939;
    dv[2] = 32'h4E4E4E4E;

    // Single vector, k mod 4, m_ready high.
    for (int k = 0; k < FC; k++)
      add(1, f(k, 0), k == FC-1, 1, k == FC-1, 1, 0, k == FC-1, 32'hE4E4E4E4);
    add(0, 2'd3, 1, 1, 0, 1, 0, 0, 0);

    // Three back-to-back vectors, continuous stream.
    for (int v = 0; v < 3; v++)
      for (int k = 0; k < FC; k++)
        add(1, f(k, v), k == FC-1, 1, k == FC-1, 1, 0, k == FC-1, dv[v]);
    add(0, 2'd0, 0, 1, 0, 1, 0, 0, 0);

    // Early s_last at index 5; idle row also checks s_data/s_last are ignored.
    for (int k = 0; k < 6; k++)
      add(1, 2'd3, k == 5, 1, 0, 1, k == 5, 0, 0);
    add(0, 2'd3, 1, 1, 0, 1, 0, 0, 0);
    for (int k = 0; k < FC; k++)
      add(1, 2'(3 - (k % 4)), k == FC-1, 1, k == FC-1, 1, 0, k == FC-1, 32'h1B1B1B1B);
    add(0, 2'd0, 0, 1, 0, 1, 0, 0, 0);

    // Missing s_last at index 15, then a vector proving index restarted at 0.
    for (int k = 0; k < FC; k++)
      add(1, 2'd1, 0, 1, 0, 1, k == FC-1, 0, 0);
    add(0, 2'd0, 0, 1, 0, 1, 0, 0, 0);
    for (int k = 0; k < FC; k++)
      add(1, (k == 0) ? 2'd3 : 2'd0, k == FC-1, 1, k == FC-1, 1, 0, k == FC-1, 32'h00000003);
    add(0, 2'd0, 0, 1, 0, 1, 0, 0, 0);

    // Backpressure: A held while B fills, B parks in HOLD, then in-order drain.
    for (int k = 0; k < FC; k++)
      add(1, f(k, 0), k == FC-1, 0, k == FC-1, 1, 0, k == FC-1, dv[0]);
    for (int k = 0; k < FC; k++)
      add(1, f(k, 1), k == FC-1, 0, 1, k != FC-1, 0, 1, dv[0]);
    add(0, 2'd0, 0, 0, 1, 0, 0, 1, dv[0]);
    add(0, 2'd0, 0, 0, 1, 0, 0, 1, dv[0]);
    add(0, 2'd0, 0, 1, 1, 1, 0, 1, dv[1]);
    add(0, 2'd0, 0, 1, 0, 1, 0, 0, 0);

    // Reset state, asserted before any clock edge.
    drive(0, 2'd0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    check("rst m_valid", 32'(bus.m_valid), 0);
    check("rst s_ready", 32'(bus.s_ready), 0);
    check("rst frame_err", 32'(bus.frame_err), 0);
    check("rst m_data", bus.m_data, 0);
    #10 rst_n = 1'b1;
    #1 check("s_ready before first edge", 32'(bus.s_ready), 0);
    @(posedge clk); #1;
    check("s_ready after first edge", 32'(bus.s_ready), 1);

    foreach (tbl[i]) begin
      drive(tbl[i].sv, tbl[i].sd, tbl[i].sl, tbl[i].mr);
      @(posedge clk); #1;
      check($sformatf("row%0d m_valid", i), 32'(bus.m_valid), 32'(tbl[i].e_mv));
      check($sformatf("row%0d s_ready", i), 32'(bus.s_ready), 32'(tbl[i].e_sr));
      check($sformatf("row%0d frame_err", i), 32'(bus.frame_err), 32'(tbl[i].e_fe));
      if (tbl[i].chk_d)
        check($sformatf("row%0d m_data", i), bus.m_data, tbl[i].e_d);
    end

    // Reset mid-vector with a vector pending on the output.
    for (int k = 0; k < FC; k++) begin
      drive(1, f(k, 0), k == FC-1, 0);
      @(posedge clk); #1;
    end
    check("pend m_valid", 32'(bus.m_valid), 1);
    for (int k = 0; k < 8; k++) begin
      drive(1, f(k, 1), 0, 0);
      @(posedge clk); #1;
    end
    drive(0, 2'd0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst m_valid", 32'(bus.m_valid), 0);
    check("midrst s_ready", 32'(bus.s_ready), 0);
    check("midrst m_data", bus.m_data, 0);
    @(posedge clk); #3 rst_n = 1'b1;
    #1 check("midrst s_ready pre-edge", 32'(bus.s_ready), 0);
    @(posedge clk); #1;
    check("midrst s_ready post-edge", 32'(bus.s_ready), 1);
    check("midrst m_valid post-edge", 32'(bus.m_valid), 0);
    for (int k = 0; k < FC; k++) begin
      drive(1, 2'd2, k == FC-1, 1);
      @(posedge clk); #1;
      if (k < FC-1)
        check($sformatf("fresh k%0d m_valid", k), 32'(bus.m_valid), 0);
    end
    check("fresh m_valid", 32'(bus.m_valid), 1);
    check("fresh m_data", bus.m_data, 32'hAAAAAAAA);
    drive(0, 2'd0, 0, 1);
    @(posedge clk); #1;
    check("fresh drained", 32'(bus.m_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
